// File: rtl/sram_rw_masked_ext.sv
// Single-port masked-write SRAM model with an optional post-reset zero sweep and an optional output register.
// Read data appears 1 cycle after the request (2 with OUT_REG); requests made while not ready are silently dropped.
module sram_rw_masked_ext #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 14,
  parameter int DEPTH      = 1 << ADDR_W,
  parameter int GRAN       = 8,
  parameter bit OUT_REG    = 1'b0,
  parameter bit INIT_CLEAR = 1'b1,
  localparam int MW        = DATA_W / GRAN
) (
  input  logic              RW0_clk,
  input  logic              RW0_rst_n,
  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic              RW0_en,
  input  logic              RW0_wmode,
  input  logic [MW-1:0]     RW0_wmask,
  input  logic [DATA_W-1:0] RW0_wdata,
  output logic              RW0_ready,
  output logic [DATA_W-1:0] RW0_rdata,
  output logic              RW0_rvalid
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0]   CNT_LAST = IW'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_IDLE} state_t;

  state_t            state;
  logic [IW-1:0]     clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [IW-1:0]     idx;
  logic              acc;
  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] rd_dat;

  assign in_range = ({1'b0, RW0_addr} < DEPTH_V);
  assign idx      = RW0_addr[IW-1:0];
  assign acc      = RW0_en && RW0_ready;
  assign wr_fire  = acc && RW0_wmode && in_range;
  assign rd_fire  = acc && !RW0_wmode;
  assign rd_dat   = in_range ? mem[idx] : '0;

  // Ready lags entry into IDLE by one edge, so ready never overlaps a sweep write.
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      state     <= ST_RESET;
      clr_cnt   <= '0;
      RW0_ready <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          clr_cnt <= '0;
          state   <= INIT_CLEAR ? ST_CLEAR : ST_IDLE;
        end
        ST_CLEAR: begin
          if (clr_cnt == CNT_LAST) state <= ST_IDLE;
          else                     clr_cnt <= clr_cnt + 1'b1;
        end
        ST_IDLE:  RW0_ready <= 1'b1;
        default:  state <= ST_RESET;
      endcase
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < MW; i++) begin
        if (RW0_wmask[i]) mem[idx][i*GRAN +: GRAN] <= RW0_wdata[i*GRAN +: GRAN];
      end
    end
  end

  generate
    if (OUT_REG) begin : g_oreg
      logic              p_vld;
      logic [DATA_W-1:0] p_dat;
      always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
          p_vld      <= 1'b0;
          p_dat      <= '0;
          RW0_rvalid <= 1'b0;
          RW0_rdata  <= '0;
        end else begin
          p_vld      <= rd_fire;
          RW0_rvalid <= p_vld;
          if (rd_fire) p_dat     <= rd_dat;
          if (p_vld)   RW0_rdata <= p_dat;
        end
      end
    end else begin : g_direct
      always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
          RW0_rvalid <= 1'b0;
          RW0_rdata  <= '0;
        end else begin
          RW0_rvalid <= rd_fire;
          if (rd_fire) RW0_rdata <= rd_dat;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sram_rw_masked_ext.sv
// Directed bench: dut A is 16x64 with clear sweep, dut B is 12x32 with output register and no sweep.
module tb_sram_rw_masked_ext;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_en, a_wmode, a_ready, a_rvalid;
  logic [3:0]  a_addr;
  logic [7:0]  a_wmask;
  logic [63:0] a_wdata, a_rdata;

  logic        b_rst_n, b_en, b_wmode, b_ready, b_rvalid;
  logic [3:0]  b_addr;
  logic [3:0]  b_wmask;
  logic [31:0] b_wdata, b_rdata;

  int errors = 0;
  int checks = 0;

  sram_rw_masked_ext #(
    .DATA_W(64), .ADDR_W(4), .DEPTH(16), .GRAN(8), .OUT_REG(1'b0), .INIT_CLEAR(1'b1)
  ) u_dut_a (
    .RW0_clk(clk), .RW0_rst_n(a_rst_n), .RW0_addr(a_addr), .RW0_en(a_en),
    .RW0_wmode(a_wmode), .RW0_wmask(a_wmask), .RW0_wdata(a_wdata),
    .RW0_ready(a_ready), .RW0_rdata(a_rdata), .RW0_rvalid(a_rvalid)
  );

  sram_rw_masked_ext #(
    .DATA_W(32), .ADDR_W(4), .DEPTH(12), .GRAN(8), .OUT_REG(1'b1), .INIT_CLEAR(1'b0)
  ) u_dut_b (
    .RW0_clk(clk), .RW0_rst_n(b_rst_n), .RW0_addr(b_addr), .RW0_en(b_en),
    .RW0_wmode(b_wmode), .RW0_wmask(b_wmask), .RW0_wdata(b_wdata),
    .RW0_ready(b_ready), .RW0_rdata(b_rdata), .RW0_rvalid(b_rvalid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(input logic [3:0] ad, input logic wm, input logic [7:0] mk, input logic [63:0] d);
    a_en = 1'b1; a_addr = ad; a_wmode = wm; a_wmask = mk; a_wdata = d;
  endtask

  task automatic a_idle();
    a_en = 1'b0; a_wmode = 1'b0; a_wmask = '0; a_wdata = '0; a_addr = '0;
  endtask

  task automatic b_req(input logic [3:0] ad, input logic wm, input logic [3:0] mk, input logic [31:0] d);
    b_en = 1'b1; b_addr = ad; b_wmode = wm; b_wmask = mk; b_wdata = d;
  endtask

  task automatic b_idle();
    b_en = 1'b0; b_wmode = 1'b0; b_wmask = '0; b_wdata = '0; b_addr = '0;
  endtask

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_idle(); b_idle();
    tick(); tick();
    chk("a_rst_ready", a_ready, 0);
    chk("a_rst_rvalid", a_rvalid, 0);
    chk("a_rst_rdata", a_rdata, 0);
    chk("b_rst_ready", b_ready, 0);
    chk("b_rst_rvalid", b_rvalid, 0);
    chk("b_rst_rdata", b_rdata, 0);

    // Release both; A sweeps 16 words, B is ready after one cycle.
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      if (i >= 4 && i <= 5)        a_req(4'd1, 1'b0, 8'h00, 64'h0);
      else if (i >= 10 && i <= 16) a_req(4'd5, 1'b1, 8'hFF, 64'hAA);
      else                         a_idle();
      tick();
      chk("a_clear_ready", a_ready, (i == 18));
      chk("a_clear_rvalid", a_rvalid, 0);
      if (i <= 2) chk("b_ready_timing", b_ready, (i == 2));
    end
    a_idle();

    // Every word reads back zero, one rvalid per read, including the dropped-write address 5.
    for (int i = 0; i < 16; i++) begin
      a_req(4'(i), 1'b0, 8'h00, 64'h0);
      tick();
      chk("a_sweep_rvalid", a_rvalid, 1);
      chk("a_sweep_rdata", a_rdata, 0);
    end
    a_idle();
    tick();
    chk("a_rvalid_pulse", a_rvalid, 0);

    a_req(4'd3, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF); tick();
    a_req(4'd3, 1'b1, 8'h0F, 64'h1122_3344_5566_7788); tick();
    a_req(4'd3, 1'b0, 8'h00, 64'h0);                   tick();
    chk("a_mask_rvalid", a_rvalid, 1);
    chk("a_mask_rdata", a_rdata, 64'hFFFF_FFFF_5566_7788);

    a_req(4'd2, 1'b1, 8'hFF, 64'h5A); tick();
    chk("a_wr_no_rvalid", a_rvalid, 0);
    a_req(4'd2, 1'b0, 8'h00, 64'h0);  tick();
    chk("a_b2b_rdata", a_rdata, 64'h5A);
    a_req(4'd2, 1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF); tick();
    a_req(4'd2, 1'b0, 8'h00, 64'h0);  tick();
    chk("a_zero_mask", a_rdata, 64'h5A);

    a_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a_hold_idle", a_rdata, 64'h5A);
      chk("a_hold_rvalid", a_rvalid, 0);
    end
    a_req(4'd9, 1'b1, 8'hFF, 64'h77); tick();
    chk("a_hold_write", a_rdata, 64'h5A);
    a_idle();

    // Reset from IDLE, then again partway through the sweep.
    a_rst_n = 1'b0; #1;
    chk("a_rst2_rdata", a_rdata, 0);
    chk("a_rst2_ready", a_ready, 0);
    tick();
    a_rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) tick();
    a_rst_n = 1'b0; #1;
    chk("a_midclr_ready", a_ready, 0);
    chk("a_midclr_rvalid", a_rvalid, 0);
    chk("a_midclr_rdata", a_rdata, 0);
    tick(); tick();
    a_rst_n = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick();
      chk("a_reclear_ready", a_ready, (i == 18));
    end
    a_req(4'd9, 1'b0, 8'h00, 64'h0); tick();
    chk("a_reclear_rdata", a_rdata, 0);
    chk("a_reclear_rvalid", a_rvalid, 1);
    a_idle();

    // B: output register adds a cycle of latency.
    b_req(4'd4, 1'b1, 4'hF, 32'hDEAD_BEEF); tick();
    chk("b_wr_rvalid", b_rvalid, 0);
    b_req(4'd4, 1'b0, 4'h0, 32'h0); tick();
    chk("b_lat1_rvalid", b_rvalid, 0);
    b_idle(); tick();
    chk("b_lat2_rvalid", b_rvalid, 1);
    chk("b_lat2_rdata", b_rdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_hold_rdata", b_rdata, 32'hDEAD_BEEF);
      chk("b_hold_rvalid", b_rvalid, 0);
    end
    b_req(4'd7, 1'b1, 4'hF, 32'h0BAD_F00D); tick();
    chk("b_hold_wr", b_rdata, 32'hDEAD_BEEF);
    b_idle(); tick();
    chk("b_hold_wr2", b_rdata, 32'hDEAD_BEEF);
    chk("b_hold_wr_rvalid", b_rvalid, 0);

    // Out-of-range write is ignored and the read returns zero with rvalid.
    b_req(4'd13, 1'b1, 4'hF, 32'h1234_5678); tick();
    b_req(4'd13, 1'b0, 4'h0, 32'h0);         tick();
    chk("b_oor_pipe", b_rvalid, 0);
    b_req(4'd4, 1'b0, 4'h0, 32'h0);          tick();
    chk("b_oor_rvalid", b_rvalid, 1);
    chk("b_oor_rdata", b_rdata, 0);
    b_idle(); tick();
    chk("b_b2b_rvalid", b_rvalid, 1);
    chk("b_b2b_rdata", b_rdata, 32'hDEAD_BEEF);
    tick();
    chk("b_b2b_pulse", b_rvalid, 0);

    // Reset with a read in the output pipeline discards it.
    b_req(4'd4, 1'b0, 4'h0, 32'h0); tick();
    b_idle();
    b_rst_n = 1'b0; #1;
    chk("b_rst_mid_rvalid", b_rvalid, 0);
    chk("b_rst_mid_rdata", b_rdata, 0);
    tick();
    b_rst_n = 1'b1;
    tick();
    chk("b_rst_mid_rv1", b_rvalid, 0);
    tick();
    chk("b_rst_mid_rv2", b_rvalid, 0);
    chk("b_rst_mid_ready", b_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
